// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between the writeback requesters and the register file:
// clear request, two valid/ready requesters, and the decoder-facing write outputs.
interface regfile_wr_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              clr;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              init_busy;

  // Requester / register-file side.
  modport master (
    output clr,
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  we, waddr, wdata, init_busy
  );

  // Arbiter side.
  modport slave (
    input  clr,
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output we, waddr, wdata, init_busy
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port sequencer: zero-fills every register after reset or
// clear, then shares the port round-robin between the ALU and load writebacks.
module regfile_wr_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  regfile_wr_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NREGS - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              grant0, grant1;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, grant and write-port decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    grant0  = 1'b0;
    grant1  = 1'b0;

    case (state_q)
      ST_INIT: begin
        we_d    = 1'b1;
        waddr_d = cnt_q[ADDR_W-1:0];
        wdata_d = '0;
        busy_d  = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        busy_d = 1'b0;
        if (bus.clr) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          // rr_q names the requester favoured when both are pending.
          if (bus.req0_valid && (!bus.req1_valid || !rr_q)) begin
            grant0 = 1'b1;
          end else if (bus.req1_valid) begin
            grant1 = 1'b1;
          end

          // Register 0 is hardwired zero: accept the write but keep WE low.
          if (grant0) begin
            we_d    = (bus.req0_addr != '0);
            waddr_d = bus.req0_addr;
            wdata_d = bus.req0_data;
            rr_d    = 1'b1;
          end else if (grant1) begin
            we_d    = (bus.req1_addr != '0);
            waddr_d = bus.req1_addr;
            wdata_d = bus.req1_data;
            rr_d    = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.init_busy  = busy_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: vector table plus hand-built
// clear/reset sequences, with registered outputs checked through a scoreboard.
module tb_regfile_wr_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;

  logic clk;
  logic rst_n;

  regfile_wr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wr_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NREGS (NREGS)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
  } out_t;

  typedef struct {
    logic              clr;
    logic              v0;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d0;
    logic              v1;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d1;
    logic              r0;
    logic              r1;
    out_t              out;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  out_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(
    input logic clr, input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
    input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
    input logic r0, input logic r1,
    input logic we, input logic [ADDR_W-1:0] waddr, input logic [DATA_W-1:0] wdata, input logic busy);
    vec_t v;
    v.clr = clr; v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1;
    v.out.we = we; v.out.waddr = waddr; v.out.wdata = wdata; v.out.busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle from the negedge, check READY, then score the registered outputs.
  task automatic apply(input vec_t v);
    out_t e;
    bus.clr        = v.clr;
    bus.req0_valid = v.v0;
    bus.req0_addr  = v.a0;
    bus.req0_data  = v.d0;
    bus.req1_valid = v.v1;
    bus.req1_addr  = v.a1;
    bus.req1_data  = v.d1;
    #1;
    check("req0_ready", DATA_W'(bus.req0_ready), DATA_W'(v.r0));
    check("req1_ready", DATA_W'(bus.req1_ready), DATA_W'(v.r1));
    sb.push_back(v.out);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("we",        DATA_W'(bus.we),        DATA_W'(e.we));
    check("waddr",     DATA_W'(bus.waddr),     DATA_W'(e.waddr));
    check("wdata",     bus.wdata,              e.wdata);
    check("init_busy", DATA_W'(bus.init_busy), DATA_W'(e.busy));
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},     DATA_W'(bus.we),         '0);
    check({tag, "_waddr"},  DATA_W'(bus.waddr),      '0);
    check({tag, "_wdata"},  bus.wdata,               '0);
    check({tag, "_busy"},   DATA_W'(bus.init_busy),  DATA_W'(1));
    check({tag, "_ready0"}, DATA_W'(bus.req0_ready), '0);
    check({tag, "_ready1"}, DATA_W'(bus.req1_ready), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.clr        = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd4;
    bus.req0_data  = 32'h1;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_data  = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;

    // Initial zero-fill; CLR pulses here must be ignored.
    for (int i = 0; i < int'(NREGS); i++)
      apply(mk((i == 5 || i == 6), 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'(i), 0, 1));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd31, 0, 0));

    // RUN-mode arbitration vectors.
    tbl.push_back(mk(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0,          1, 0, 1, 5'd5,  32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 5'd5,  32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 5'd12, 32'h1234,             0, 1, 1, 5'd12, 32'h1234,     0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 5'd3, 32'h11, 1, 5'd7, 32'h22, (i % 2 == 0), (i % 2 == 1), 1,
                       (i % 2 == 0) ? 5'd3 : 5'd7, (i % 2 == 0) ? 32'h11 : 32'h22, 0));
    tbl.push_back(mk(0, 1, 5'd20, 32'hA5, 0, 0, 0,               1, 0, 1, 5'd20, 32'hA5,       0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 5'd0, 32'hFFFF,              0, 1, 0, 5'd0,  32'hFFFF,     0));
    tbl.push_back(mk(0, 1, 5'd3, 32'h11, 1, 5'd7, 32'h22,        1, 0, 1, 5'd3,  32'h11,       0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 5'd3,  32'h11,       0));
    tbl.push_back(mk(0, 1, 5'd9, 32'hAAAA, 1, 5'd9, 32'hBBBB,    0, 1, 1, 5'd9,  32'hBBBB,     0));
    tbl.push_back(mk(0, 1, 5'd9, 32'hAAAA, 0, 0, 0,              1, 0, 1, 5'd9,  32'hAAAA,     0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 5'd9,  32'hAAAA,     0));
    tbl.push_back(mk(0, 1, 5'd0, 32'h55, 0, 0, 0,                1, 0, 0, 5'd0,  32'h55,       0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 5'd0,  32'h55,       0));
    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i]);

    // CLR with a held request: it stalls through the whole clear, then lands.
    apply(mk(1, 0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 0, 5'd0, 32'h55, 1));
    for (int i = 0; i < int'(NREGS); i++)
      apply(mk(0, 0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 1, 5'(i), 0, 1));
    apply(mk(0, 0, 0, 0, 1, 5'd9, 32'h99, 0, 1, 1, 5'd9, 32'h99, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 5'd9, 32'h99, 0));

    // Asynchronous reset in the middle of a clear sequence.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 32'h99, 1));
    for (int i = 0; i <= 10; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'(i), 0, 1));
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk);
    #1;
    check_reset_vals("held_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(NREGS); i++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'(i), 0, 1));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd31, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
